fetch_pc_unit: RTL

- Fetch stage directly upstream of the branch resolver.
- Owns the architectural PC, issues in-order instruction-memory reads, and buffers returned instructions in a small FIFO toward decode.
- Consumes taken_br / br_tgt_pc from the branch unit to redirect the stream, discarding wrong-path responses still in flight.
- Traps misaligned branch targets.

---
 rtl/fetch_pc_unit.sv | 132 +++++++++++++
 1 files changed

// File: rtl/fetch_pc_unit.sv
// rtl/fetch_pc_unit.sv - Fetch PC, in-order imem request issue and instruction FIFO with redirect/trap
module fetch_pc_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        taken_br,
  input  logic [31:0] br_tgt_pc,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_pc,
  output logic [31:0] if_instr,
  output logic        fetch_fault
);
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW-1:0] LAST_IDX = PW'(DEPTH - 1);
  localparam logic [CW:0]   CREDITS  = (CW+1)'(DEPTH);
  localparam logic [CW-1:0] FULL     = CW'(DEPTH);

  typedef enum logic {RUN, HALT} state_t;

  state_t        state_q, state_d;
  logic [31:0]   pc_q, pc_d, resp_pc_q, resp_pc_d;
  logic [CW-1:0] inflight_q, inflight_d, stale_q, stale_d, count_q, count_d;
  logic [PW-1:0] rd_q, rd_d, wr_q, wr_d;
  logic          fault_q, fault_d;
  logic [63:0]   mem_q [DEPTH];
  logic [63:0]   mem_d [DEPTH];
  logic          redirect, accept, drop, push, pop;
  logic [CW:0]   used;

  function automatic logic [PW-1:0] next_idx(input logic [PW-1:0] i);
    return (i == LAST_IDX) ? '0 : i + PW'(1);
  endfunction

  // Credits cover both outstanding reads and buffered entries, so the FIFO cannot overflow.
  assign used           = {1'b0, inflight_q} + {1'b0, count_q};
  assign redirect       = taken_br && (state_q == RUN);
  assign imem_req_valid = rst_n && (state_q == RUN) && !taken_br && (used < CREDITS);
  assign imem_req_addr  = pc_q;
  assign accept         = imem_req_valid && imem_req_ready;
  assign if_valid       = (count_q != '0);
  assign pop            = if_valid && if_ready;
  assign drop           = imem_resp_valid && (redirect || (stale_q != '0));
  assign push           = imem_resp_valid && !drop;
  assign if_pc          = mem_q[rd_q][63:32];
  assign if_instr       = mem_q[rd_q][31:0];
  assign fetch_fault    = fault_q;

  always_comb begin
    state_d    = state_q;
    fault_d    = fault_q;
    pc_d       = pc_q;
    resp_pc_d  = resp_pc_q;
    inflight_d = inflight_q;
    stale_d    = stale_q;
    count_d    = count_q;
    rd_d       = rd_q;
    wr_d       = wr_q;
    mem_d      = mem_q;

    if (accept && !imem_resp_valid)      inflight_d = inflight_q + CW'(1);
    else if (!accept && imem_resp_valid) inflight_d = inflight_q - CW'(1);

    if (accept) pc_d = pc_q + 32'd4;

    if (push) begin
      mem_d[wr_q] = {resp_pc_q, imem_resp_data};
      wr_d        = next_idx(wr_q);
      resp_pc_d   = resp_pc_q + 32'd4;
    end
    if (pop) rd_d = next_idx(rd_q);

    if (push && !pop)      count_d = count_q + CW'(1);
    else if (!push && pop) count_d = count_q - CW'(1);

    if (imem_resp_valid && (stale_q != '0)) stale_d = stale_q - CW'(1);

    // Everything still outstanding becomes wrong-path once the stream is redirected.
    if (redirect) begin
      pc_d      = br_tgt_pc;
      resp_pc_d = br_tgt_pc;
      stale_d   = imem_resp_valid ? inflight_q - CW'(1) : inflight_q;
      count_d   = '0;
      rd_d      = '0;
      wr_d      = '0;
      if (br_tgt_pc[1:0] != 2'b00) begin
        state_d = HALT;
        fault_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= RUN;
      fault_q    <= 1'b0;
      pc_q       <= RESET_PC;
      resp_pc_q  <= RESET_PC;
      inflight_q <= '0;
      stale_q    <= '0;
      count_q    <= '0;
      rd_q       <= '0;
      wr_q       <= '0;
    end else begin
      state_q    <= state_d;
      fault_q    <= fault_d;
      pc_q       <= pc_d;
      resp_pc_q  <= resp_pc_d;
      inflight_q <= inflight_d;
      stale_q    <= stale_d;
      count_q    <= count_d;
      rd_q       <= rd_d;
      wr_q       <= wr_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(push && !pop && (count_q == FULL)));

endmodule
